// File: rtl/ddr_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped DDR line cache.
package ddr_cache_pkg;

    // Controller states of the cache front end
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REQ    = 2'd2,
        ST_FILL   = 2'd3
    } cache_state_t;

    localparam int BURSTCNT_W = 8;

    // Word-offset bits inside one line
    function automatic int ofs_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index bits (zero for a single-line cache)
    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Width used for index signals; never zero so ports stay legal with one line
    function automatic int idx_store_bits(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

    // Tag bits left over above offset and index
    function automatic int tag_bits(input int addr_w, input int line_words, input int lines);
        return addr_w - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/ddr_cache_tag_store.sv
// Tag array plus per-line valid bits: one lookup port, one fill write port,
// and a whole-cache invalidate that wins over a coincident fill.
module ddr_cache_tag_store
    import ddr_cache_pkg::*;
#(
    parameter int LINES = 4,
    parameter int IDX_W = 2,
    parameter int TAG_W = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             flush_clr
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];

    // Valid bits: flush clears everything, including a line completing this edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush_clr) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Tag storage needs no reset; a tag is only trusted behind its valid bit
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tags[fill_idx] <= fill_tag;
        end
    end

    // Hit when the indexed line is valid and holds the requested tag
    always_comb begin
        lookup_hit = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
    end

endmodule

// File: rtl/ddr_line_cache.sv
// Direct-mapped read cache between the PVR read client and the DDR3 read port.
// A miss fetches the whole line in one burst; flush invalidates every line.
// Optional build macro DDR_CACHE_STATS_EN adds 32-bit hit/miss counters.
module ddr_line_cache
    import ddr_cache_pkg::*;
#(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 64,
    parameter int LINE_WORDS = 8,
    parameter int LINES      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     ddram_addr_in,
    input  logic                  ddram_rd_in,
    input  logic                  flush_in,
    output logic                  ddram_busy_out,
    output logic [DATA_W-1:0]     ddram_readdata_out,
    output logic                  ddram_valid_out,
    output logic [ADDR_W-1:0]     ddram_addr_out,
    output logic [BURSTCNT_W-1:0] ddram_burstcnt_out,
    output logic                  ddram_rd_out,
    input  logic                  ddram_waitrequest_in,
    input  logic                  ddram_valid_in,
    input  logic [DATA_W-1:0]     ddram_readdata_in
`ifdef DDR_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_out,
    output logic [31:0]           miss_count_out
`endif
);

    localparam int OFS   = ofs_bits(LINE_WORDS);
    localparam int IDX   = idx_bits(LINES);
    localparam int IDX_W = idx_store_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_W, LINE_WORDS, LINES);

    cache_state_t      state;
    logic [ADDR_W-1:0] req_addr;
    logic [OFS-1:0]    req_ofs;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [OFS-1:0]    beat_cnt;
    logic              flush_pend;
    logic              lookup_hit;
    logic              fill_last;
    logic              flush_clr;
    logic [DATA_W-1:0] line_data [LINES][LINE_WORDS];

    assign req_ofs = req_addr[OFS-1:0];
    assign req_tag = req_addr[ADDR_W-1:OFS+IDX];

    if (IDX > 0) begin : g_idx
        assign req_idx = req_addr[OFS+IDX-1:OFS];
    end else begin : g_no_idx
        assign req_idx = '0;
    end

    // Final beat of a fill, and the two situations that wipe all valid bits
    always_comb begin
        fill_last = (state == ST_FILL) && ddram_valid_in &&
                    (beat_cnt == OFS'(LINE_WORDS - 1));
        flush_clr = (flush_in && ((state == ST_IDLE) || (state == ST_LOOKUP))) ||
                    (fill_last && (flush_pend || flush_in));
    end

    ddr_cache_tag_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_store (
        .clock      (clock),
        .reset_n    (reset_n),
        .lookup_idx (req_idx),
        .lookup_tag (req_tag),
        .lookup_hit (lookup_hit),
        .fill_en    (fill_last),
        .fill_idx   (req_idx),
        .fill_tag   (req_tag),
        .flush_clr  (flush_clr)
    );

    // Latch the client address at acceptance; it stays put until the reply
    always_ff @(posedge clock) begin
        if ((state == ST_IDLE) && ddram_rd_in) begin
            req_addr <= ddram_addr_in;
        end
    end

    // Line data array: beats land in arrival order at the requested index
    always_ff @(posedge clock) begin
        if ((state == ST_FILL) && ddram_valid_in) begin
            line_data[req_idx][beat_cnt] <= ddram_readdata_in;
        end
    end

    // Request/lookup/burst/fill sequencer with registered client and DDR outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            ddram_busy_out     <= 1'b0;
            ddram_valid_out    <= 1'b0;
            ddram_readdata_out <= '0;
            ddram_addr_out     <= '0;
            ddram_burstcnt_out <= '0;
            ddram_rd_out       <= 1'b0;
            beat_cnt           <= '0;
            flush_pend         <= 1'b0;
        end else begin
            ddram_valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ddram_rd_in) begin
                        ddram_busy_out <= 1'b1;
                        state          <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (lookup_hit) begin
                        ddram_readdata_out <= line_data[req_idx][req_ofs];
                        ddram_valid_out    <= 1'b1;
                        ddram_busy_out     <= 1'b0;
                        state              <= ST_IDLE;
                    end else begin
                        ddram_addr_out     <= {req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                        ddram_burstcnt_out <= BURSTCNT_W'(LINE_WORDS);
                        ddram_rd_out       <= 1'b1;
                        state              <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A flush here cannot touch the valid bits until the fill lands
                    if (flush_in) begin
                        flush_pend <= 1'b1;
                    end
                    if (!ddram_waitrequest_in) begin
                        ddram_rd_out <= 1'b0;
                        beat_cnt     <= '0;
                        state        <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_last) begin
                        flush_pend <= 1'b0;
                    end else if (flush_in) begin
                        flush_pend <= 1'b1;
                    end
                    if (ddram_valid_in) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (fill_last) begin
                            state <= ST_LOOKUP;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DDR_CACHE_STATS_EN
    logic fill_done;

    // Outcome counters; the re-lookup straight after a fill is not a hit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_out  <= '0;
            miss_count_out <= '0;
            fill_done      <= 1'b0;
        end else begin
            if (fill_last) begin
                fill_done <= 1'b1;
            end else if (state == ST_LOOKUP) begin
                fill_done <= 1'b0;
            end
            if (state == ST_LOOKUP) begin
                if (!lookup_hit) begin
                    miss_count_out <= miss_count_out + 32'd1;
                end else if (!fill_done) begin
                    hit_count_out <= hit_count_out + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_line_cache.sv
// Self-checking bench for ddr_line_cache: directed vector table, hand-written
// corner sequences and a randomized phase against a line-residency model.
module tb_ddr_line_cache;

    localparam int ADDR_W     = 29;
    localparam int DATA_W     = 64;
    localparam int LINE_WORDS = 8;
    localparam int LINES      = 4;

    logic              clock;
    logic              reset_n;
    logic [ADDR_W-1:0] ddram_addr_in;
    logic              ddram_rd_in;
    logic              flush_in;
    logic              ddram_busy_out;
    logic [DATA_W-1:0] ddram_readdata_out;
    logic              ddram_valid_out;
    logic [ADDR_W-1:0] ddram_addr_out;
    logic [7:0]        ddram_burstcnt_out;
    logic              ddram_rd_out;
    logic              ddram_waitrequest_in;
    logic              ddram_valid_in;
    logic [DATA_W-1:0] ddram_readdata_in;
`ifdef DDR_CACHE_STATS_EN
    logic [31:0]       hit_count_out;
    logic [31:0]       miss_count_out;
`endif

    ddr_line_cache #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .LINES(LINES)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .ddram_addr_in        (ddram_addr_in),
        .ddram_rd_in          (ddram_rd_in),
        .flush_in             (flush_in),
        .ddram_busy_out       (ddram_busy_out),
        .ddram_readdata_out   (ddram_readdata_out),
        .ddram_valid_out      (ddram_valid_out),
        .ddram_addr_out       (ddram_addr_out),
        .ddram_burstcnt_out   (ddram_burstcnt_out),
        .ddram_rd_out         (ddram_rd_out),
        .ddram_waitrequest_in (ddram_waitrequest_in),
        .ddram_valid_in       (ddram_valid_in),
        .ddram_readdata_in    (ddram_readdata_in)
`ifdef DDR_CACHE_STATS_EN
        ,
        .hit_count_out        (hit_count_out),
        .miss_count_out       (miss_count_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass, n_total;

    // DDR responder state
    int          beats_left, beat_idx, burst_count, overlap_err;
    int          force_wait, stall_seen, stall_bad;
    bit          rand_wait, rand_gap;
    logic [28:0] beat_addr, last_burst_addr, stall_addr;
    logic [7:0]  last_burst_cnt, stall_cnt;

    // Reference model: which line each index holds and which burst filled it
    bit          m_valid [LINES];
    logic [23:0] m_tag   [LINES];
    int          m_epoch [LINES];
    int          mdl_hits, mdl_misses;

    typedef struct {
        logic [28:0] addr;
        bit          flush_before;
        bit          exp_hit;
    } vec_t;
    vec_t vecs [10];

    // Memory contents: address plus the number of the burst that carried it
    function automatic logic [63:0] ddr_word(input logic [28:0] a, input int epoch);
        logic [15:0] e;
        e = epoch[15:0];
        return {e, 16'hA5C3, 3'b000, a};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, " busy"},      ddram_busy_out, 0);
        check({pfx, " valid"},     ddram_valid_out, 0);
        check({pfx, " readdata"},  ddram_readdata_out, 0);
        check({pfx, " addr_out"},  ddram_addr_out, 0);
        check({pfx, " burstcnt"},  ddram_burstcnt_out, 0);
        check({pfx, " rd_out"},    ddram_rd_out, 0);
    endtask

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    endtask

    function automatic bit model_hit(input logic [28:0] a);
        int i;
        i = int'(a[4:3]);
        return m_valid[i] && (m_tag[i] == a[28:5]);
    endfunction

    // DDR3 read port: optional stalls, beats with optional gaps, junk between beats
    initial begin
        beats_left = 0; beat_idx = 0; burst_count = 0; overlap_err = 0;
        force_wait = 0; stall_seen = 0; stall_bad = 0; rand_wait = 0; rand_gap = 0;
        beat_addr = '0; last_burst_addr = '0; last_burst_cnt = '0;
        stall_addr = '0; stall_cnt = '0;
        ddram_waitrequest_in = 1'b0;
        ddram_valid_in = 1'b0;
        ddram_readdata_in = '0;
        forever begin
            @(negedge clock);
            ddram_valid_in = 1'b0;
            ddram_readdata_in = {$urandom, $urandom};
            if (beats_left > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
                ddram_valid_in = 1'b1;
                ddram_readdata_in = ddr_word(beat_addr + 29'(beat_idx), burst_count);
                beat_idx++;
                beats_left--;
            end
            if (force_wait > 0 && ddram_rd_out) begin
                ddram_waitrequest_in = 1'b1;
                if (stall_seen == 0) begin
                    stall_addr = ddram_addr_out;
                    stall_cnt  = ddram_burstcnt_out;
                end else if (ddram_addr_out !== stall_addr || ddram_burstcnt_out !== stall_cnt) begin
                    stall_bad++;
                end
                stall_seen++;
                force_wait--;
            end else begin
                ddram_waitrequest_in = rand_wait && ($urandom_range(0, 2) == 0);
            end
            if (ddram_rd_out && !ddram_waitrequest_in) begin
                if (beats_left != 0) overlap_err++;
                burst_count++;
                last_burst_addr = ddram_addr_out;
                last_burst_cnt  = ddram_burstcnt_out;
                beat_addr  = ddram_addr_out;
                beat_idx   = 0;
                beats_left = LINE_WORDS;
            end
        end
    end

    task automatic do_read(input logic [28:0] a, input bit with_flush,
                           output logic [63:0] d, output int cyc, output bit ok);
        int n;
        n = 0; d = '0; ok = 0;
        while (ddram_busy_out && n < 500) begin @(negedge clock); n++; end
        ddram_addr_in = a;
        ddram_rd_in   = 1'b1;
        flush_in      = with_flush;
        @(negedge clock);
        ddram_rd_in = 1'b0;
        flush_in    = 1'b0;
        cyc = 1;
        while (!ddram_valid_out && cyc < 1000) begin @(negedge clock); cyc++; end
        if (ddram_valid_out) begin
            ok = 1;
            d  = ddram_readdata_out;
        end
    endtask

    task automatic model_read(input logic [28:0] a, input bit exp_hit,
                              input bit with_flush, input string nm);
        logic [63:0] d;
        int cyc, b0, i;
        bit ok;
        i  = int'(a[4:3]);
        b0 = burst_count;
        do_read(a, with_flush, d, cyc, ok);
        check({nm, " reply"}, ok, 1);
        if (exp_hit) begin
            check({nm, " hit data"},    d, ddr_word(a, m_epoch[i]));
            check({nm, " hit bursts"},  burst_count, b0);
            check({nm, " hit latency"}, cyc, 2);
            mdl_hits++;
        end else begin
            check({nm, " miss bursts"}, burst_count, b0 + 1);
            check({nm, " burst addr"},  last_burst_addr, {a[28:3], 3'b000});
            check({nm, " burstcnt"},    last_burst_cnt, LINE_WORDS);
            check({nm, " miss data"},   d, ddr_word(a, burst_count));
            m_valid[i] = 1;
            m_tag[i]   = a[28:5];
            m_epoch[i] = burst_count;
            mdl_misses++;
        end
    endtask

    initial begin
        logic [63:0] d;
        int cyc, b0, n, extra;
        bit ok, h, fl;
        logic [28:0] a;

        n_pass = 0; n_total = 0; mdl_hits = 0; mdl_misses = 0;
        model_flush();
        for (int i = 0; i < LINES; i++) begin m_tag[i] = '0; m_epoch[i] = 0; end

        vecs[0] = '{29'h100, 0, 0};
        vecs[1] = '{29'h107, 0, 1};
        vecs[2] = '{29'h120, 0, 0};
        vecs[3] = '{29'h100, 0, 0};
        vecs[4] = '{29'h108, 0, 0};
        vecs[5] = '{29'h100, 0, 1};
        vecs[6] = '{29'h10F, 0, 1};
        vecs[7] = '{29'h103, 1, 0};
        vecs[8] = '{29'h101, 0, 1};
        vecs[9] = '{29'h108, 0, 0};

        reset_n = 1'b0; ddram_addr_in = '0; ddram_rd_in = 1'b0; flush_in = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_outputs_zero("post_reset");

        // Directed table
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].flush_before) begin
                flush_in = 1'b1;
                @(negedge clock);
                flush_in = 1'b0;
                model_flush();
            end
            model_read(vecs[v].addr, vecs[v].exp_hit, 0, $sformatf("vec%0d", v));
        end

        // Controller stall held for five cycles during the request
        stall_seen = 0; stall_bad = 0; force_wait = 5;
        model_read(29'h140, 0, 0, "stall");
        check("stall cycles", stall_seen, 5);
        check("stall stable", stall_bad, 0);

        // Flush during the fill forces a second burst before the reply
        b0 = burst_count;
        fork
            do_read(29'h100, 0, d, cyc, ok);
            begin
                n = 0;
                while (!(beats_left >= 2 && beats_left <= 6) && n < 500) begin
                    @(negedge clock); n++;
                end
                flush_in = 1'b1;
                @(negedge clock);
                flush_in = 1'b0;
            end
        join
        check("pend_flush reply", ok, 1);
        check("pend_flush bursts", burst_count, b0 + 2);
        check("pend_flush addr", last_burst_addr, 29'h100);
        check("pend_flush data", d, ddr_word(29'h100, burst_count));
        model_flush();
        m_valid[0] = 1; m_tag[0] = 24'h8; m_epoch[0] = burst_count;
        mdl_misses += 2;
        model_read(29'h105, 1, 0, "pend_flush_reread");

        // Requests while busy are dropped
        b0 = burst_count;
        @(negedge clock);
        ddram_addr_in = 29'h218; ddram_rd_in = 1'b1;
        @(negedge clock);
        check("busy after accept", ddram_busy_out, 1);
        ddram_addr_in = 29'h3F8;
        repeat (3) @(negedge clock);
        ddram_rd_in = 1'b0;
        n = 0;
        while (!ddram_valid_out && n < 500) begin @(negedge clock); n++; end
        check("busy_drop reply", ddram_valid_out, 1);
        check("busy_drop data", ddram_readdata_out, ddr_word(29'h218, burst_count));
        check("busy_drop bursts", burst_count, b0 + 1);
        m_valid[3] = 1; m_tag[3] = 24'h10; m_epoch[3] = burst_count;
        mdl_misses++;
        extra = 0;
        repeat (30) begin
            @(negedge clock);
            if (ddram_valid_out || ddram_busy_out) extra++;
        end
        check("busy_drop no extra", extra, 0);
        check("busy_drop no burst", burst_count, b0 + 1);
        model_read(29'h21F, 1, 0, "busy_drop_reread");

        // Reset in the middle of a fill
        ddram_addr_in = 29'h1A8; ddram_rd_in = 1'b1;
        @(negedge clock);
        ddram_rd_in = 1'b0;
        n = 0;
        while (beats_left != 4 && n < 500) begin @(negedge clock); n++; end
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midfill_reset");
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (beats_left > 0 && n < 500) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        check("midfill idle", ddram_busy_out, 0);
        model_flush();
        mdl_hits = 0; mdl_misses = 0;
        model_read(29'h1A8, 0, 0, "midfill_reread");
        model_read(29'h100, 0, 0, "midfill_other");

        // Randomized traffic with stalls, beat gaps and flushes
        rand_wait = 1; rand_gap = 1;
        for (int r = 0; r < 150; r++) begin
            a = 29'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a[28] = 1'b1;
            fl = 0;
            case ($urandom_range(0, 9))
                0: begin
                    flush_in = 1'b1;
                    @(negedge clock);
                    flush_in = 1'b0;
                    model_flush();
                end
                1: begin
                    fl = 1;
                    model_flush();
                end
                default: ;
            endcase
            h = model_hit(a);
            model_read(a, h, fl, $sformatf("rand%0d", r));
        end

        check("no overlapping bursts", overlap_err, 0);
`ifdef DDR_CACHE_STATS_EN
        check("hit counter", hit_count_out, mdl_hits);
        check("miss counter", miss_count_out, mdl_misses);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
